// File: rtl/zigbee_fifo_pkg.sv
// Shared definitions for the transmit and receive byte FIFOs.
package zigbee_fifo_pkg;

  // Serializer / deserializer state.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int unsigned DefaultWidth     = 8;
  localparam int unsigned DefaultDepth     = 64;
  localparam int unsigned DefaultClkPerBit = 4;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_tx_serializer.sv
// Parallel-in/serial-out back end: shifts each loaded byte out LSB-first,
// holding every bit for CLK_PER_BIT cycles, with back-to-back frames.
module fifo_tx_serializer
  import zigbee_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned CLK_PER_BIT = DefaultClkPerBit
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_enable,
  input  logic             fifo_empty,
  input  logic             load,
  input  logic [WIDTH-1:0] byte_in,
  output logic             req_pop,
  output logic             data_out,
  output logic             data_valid,
  output logic             tx_busy
);

  localparam int unsigned ClkCntW = cnt_w(CLK_PER_BIT);
  localparam int unsigned BitCntW = cnt_w(WIDTH);
  localparam logic [ClkCntW-1:0] ClkLast = ClkCntW'(CLK_PER_BIT - 1);
  localparam logic [BitCntW-1:0] BitLast = BitCntW'(WIDTH - 1);

  ser_state_e         state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [ClkCntW-1:0] clk_cnt_q, clk_cnt_d;
  logic               bit_end;
  logic               frame_end;

  assign bit_end   = (state_q == SHIFT) && (clk_cnt_q == ClkLast);
  assign frame_end = bit_end && (bit_cnt_q == BitLast);

  // Ask storage for a byte when idle or on the final cycle of a frame.
  assign req_pop = tx_enable && !fifo_empty && ((state_q == IDLE) || frame_end);

  // Next-state, shift register and bit/clock counters.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d   = byte_in;
          bit_cnt_d = '0;
          clk_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (frame_end) begin
            if (load) begin
              // Next frame starts with no idle gap.
              shreg_d   = byte_in;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serializer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
    end
  end

  // Frame outputs are only meaningful while shifting.
  always_comb begin
    data_valid = (state_q == SHIFT);
    tx_busy    = (state_q == SHIFT);
    data_out   = (state_q == SHIFT) && shreg_q[0];
  end

endmodule

// File: rtl/fifo_tx.sv
// Transmit byte FIFO: APB write-only front end, circular storage with
// wrap-bit pointers, and a serializer draining bytes when tx_enable is high.
module fifo_tx
  import zigbee_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned DEPTH       = DefaultDepth,
  parameter int unsigned CLK_PER_BIT = DefaultClkPerBit
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [WIDTH-1:0]          pwdata,
  output logic                      pready,
  output logic                      pslverr,
  input  logic                      tx_enable,
  output logic                      data_out,
  output logic                      data_valid,
  output logic                      tx_busy,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_w(DEPTH)-1:0]   level
);

  localparam int unsigned PtrW  = ptr_w(DEPTH);
  localparam int unsigned AddrW = PtrW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             access;
  logic             wr_en;
  logic             pop;
  logic [WIDTH-1:0] rd_byte;

  // Flags come from pre-edge pointers, so a write into an empty FIFO is not
  // popped in the same cycle and a write while full is refused even on a pop.
  always_comb begin
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
             (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
    level  = wr_ptr_q - rd_ptr_q;
    access = psel && penable;
    wr_en  = access && pwrite && !full;
    // Reads are unsupported; writes while full are dropped.
    pslverr = access && (!pwrite || full);
    pready  = 1'b1;
    rd_byte = mem_q[rd_ptr_q[AddrW-1:0]];
  end

  // Pointer next-state; both may move in one cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= pwdata;
  end

  fifo_tx_serializer #(
    .WIDTH       (WIDTH),
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .fifo_empty (empty),
    .load       (pop),
    .byte_in    (rd_byte),
    .req_pop    (pop),
    .data_out   (data_out),
    .data_valid (data_valid),
    .tx_busy    (tx_busy)
  );

endmodule

// File: tb/tb_fifo_tx.sv
// Randomised scoreboard bench for fifo_tx: accepted writes are queued as
// expected frames; a negedge monitor predicts pops and checks every output.
module tb_fifo_tx;

  localparam int unsigned W    = 8;
  localparam int unsigned D    = 64;
  localparam int unsigned CPB  = 4;
  localparam int unsigned LvlW = $clog2(D) + 1;

  logic            clk;
  logic            reset;
  logic            psel, penable, pwrite;
  logic [W-1:0]    pwdata;
  logic            pready, pslverr;
  logic            tx_enable;
  logic            data_out, data_valid, tx_busy;
  logic            full, empty;
  logic [LvlW-1:0] level;

  fifo_tx #(
    .WIDTH       (W),
    .DEPTH       (D),
    .CLK_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .tx_enable  (tx_enable),
    .data_out   (data_out),
    .data_valid (data_valid),
    .tx_busy    (tx_busy),
    .full       (full),
    .empty      (empty),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: byte queue, occupancy and cycles left in current frame.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_byte;
  int           mlevel   = 0;
  int           mpos     = 0;
  bit           mon_en   = 0;
  bit           rst_prev = 0;

  always @(negedge clk) begin
    int  idx;
    bit  wr_ok, pop;
    if (mon_en) begin
      if (rst_prev) chk("data_out_after_reset", {31'd0, data_out}, 32'd0);
      chk("data_valid", {31'd0, data_valid}, (mpos != 0) ? 32'd1 : 32'd0);
      chk("tx_busy", {31'd0, tx_busy}, (mpos != 0) ? 32'd1 : 32'd0);
      if (mpos != 0) begin
        idx = (W * CPB - mpos) / CPB;
        chk("data_out", {31'd0, data_out}, {31'd0, cur_byte[idx]});
      end
      chk("level", {{(32 - LvlW){1'b0}}, level}, mlevel);
      chk("empty", {31'd0, empty}, (mlevel == 0) ? 32'd1 : 32'd0);
      chk("full", {31'd0, full}, (mlevel == D) ? 32'd1 : 32'd0);
      chk("pready", {31'd0, pready}, 32'd1);
      if (psel && penable)
        chk("pslverr", {31'd0, pslverr}, (!pwrite || mlevel == D) ? 32'd1 : 32'd0);
      else
        chk("pslverr_idle", {31'd0, pslverr}, 32'd0);
    end
    // Advance the model across the coming edge.
    if (reset) begin
      exp_q.delete();
      mlevel = 0;
      mpos   = 0;
    end else begin
      wr_ok = psel && penable && pwrite && (mlevel < D);
      pop   = tx_enable && (mpos <= 1) && (mlevel > 0);
      if (pop) begin
        cur_byte = exp_q.pop_front();
        mpos     = W * CPB;
      end else if (mpos > 0) begin
        mpos--;
      end
      if (wr_ok) exp_q.push_back(pwdata);
      mlevel = mlevel + (wr_ok ? 1 : 0) - (pop ? 1 : 0);
    end
    rst_prev = reset;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb_write(input logic [W-1:0] b);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = b;
    step(1);
    penable = 1'b1;
    step(1);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    tx_enable = 1'b0;
    step(2);
    reset  = 1'b0;
    mon_en = 1'b1;
    step(2);

    // Single byte, LSB first.
    tx_enable = 1'b1;
    apb_write(8'hA5);
    step(40);

    // Three queued bytes then released back-to-back.
    tx_enable = 1'b0;
    apb_write(8'h01);
    apb_write(8'h02);
    apb_write(8'h03);
    tx_enable = 1'b1;
    step(3 * W * CPB + 6);

    // Fill to full, overflow, then write-at-full on the pop edge.
    tx_enable = 1'b0;
    for (int i = 0; i < D; i++) apb_write(W'($urandom));
    apb_write(8'hEE);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = 8'h77;
    step(1);
    penable   = 1'b1;
    tx_enable = 1'b1;
    step(1);
    psel = 1'b0; penable = 1'b0;
    apb_write(8'h5C);
    step((D + 1) * W * CPB + 10);

    // Random traffic including reads and tx_enable toggling.
    for (int c = 0; c < 1500; c++) begin
      psel    = ($urandom_range(0, 1) == 1);
      penable = psel && ($urandom_range(0, 1) == 1);
      pwrite  = ($urandom_range(0, 7) != 0);
      pwdata  = W'($urandom);
      if ($urandom_range(0, 39) == 0) tx_enable = ~tx_enable;
      step(1);
    end
    psel = 1'b0; penable = 1'b0; tx_enable = 1'b1;
    step(D * W * CPB + 50);

    // Drop tx_enable in bit 3: current byte finishes, next stays queued.
    tx_enable = 1'b0;
    apb_write(8'h3C);
    apb_write(8'hC3);
    tx_enable = 1'b1;
    step(14);
    tx_enable = 1'b0;
    step(W * CPB + 8);

    // Reset in bit 5 of a frame discards everything.
    apb_write(8'h96);
    tx_enable = 1'b1;
    step(22);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
